// File: rtl/dht11_reader.sv
// DHT11 single-wire reader.
// On an accepted sample_en it drives the host start pulse, follows the
// sensor acknowledge and decodes the 40 data bits by high-pulse width.
// After a checksum check it publishes humidity/temperature with a one-cycle
// data_valid strobe. The bus is only ever pulled low (dq_oe=1) or released.
module dht11_reader #(
  parameter int CYCLES_PER_US = 10,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        dq_in,
  output logic        dq_oe,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        data_valid,
  output logic        busy,
  output logic        err
);

  localparam int            PW        = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_US - 1);
  localparam logic [15:0]   START_US  = 16'(START_LOW_US);
  localparam logic [15:0]   THRESH_US = 16'(BIT_THRESH_US);
  localparam logic [15:0]   TMO_US    = 16'(TIMEOUT_US);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_WAIT_ACK  = 4'd2,
    ST_ACK_LOW   = 4'd3,
    ST_ACK_HIGH  = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7
  } state_t;

  // Saturating increment for the microsecond phase counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Sum of the four payload bytes modulo 256 must equal the last byte.
  function automatic logic checksum_ok(input logic [39:0] d);
    logic [7:0] sum;
    sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    return (sum == d[7:0]);
  endfunction

  state_t        state_q, state_d;
  logic          dq_meta_q, dq_sync_q;
  logic          dq_s;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_cnt_q, us_cnt_d;
  logic [15:0]   us_inc_s;
  logic          tick_s;
  logic          state_change_s;
  logic          timeout_s;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic [39:0]   shift_q, shift_d;
  logic          seen_high_q, seen_high_d;
  logic [15:0]   hum_q, hum_d;
  logic [15:0]   temp_q, temp_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic          dq_oe_q;

  // Two-flop synchronizer for the asynchronous bus level; idles high like the pulled-up bus.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dq_meta_q <= 1'b1;
      dq_sync_q <= 1'b1;
    end else begin
      dq_meta_q <= dq_in;
      dq_sync_q <= dq_meta_q;
    end
  end

  assign dq_s   = dq_sync_q;
  assign tick_s = (presc_q == PRESC_MAX);

  // us_inc_s is the elapsed time in the phase including the current cycle, so a
  // pulse of exactly N us measures N in its last cycle and exits land on whole us.
  assign us_inc_s       = tick_s ? sat_inc(us_cnt_q) : us_cnt_q;
  assign timeout_s      = (us_inc_s >= TMO_US);
  assign state_change_s = (state_d != state_q);

  // Next-state logic for the transaction FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    seen_high_d = seen_high_q;
    hum_d       = hum_q;
    temp_d      = temp_q;
    dv_d        = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          state_d = ST_START_LOW;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START_LOW: begin
        if (us_inc_s >= START_US) begin
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_START_LOW;
        end
      end
      ST_WAIT_ACK: begin
        // Our own start pulse is still in the synchronizer right after release;
        // only a low that follows a seen high is the sensor acknowledge.
        if (timeout_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!dq_s && seen_high_q) begin
          state_d = ST_ACK_LOW;
        end else if (dq_s) begin
          seen_high_d = 1'b1;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_ACK_LOW: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (dq_s) begin
          state_d = ST_ACK_HIGH;
        end else begin
          state_d = ST_ACK_LOW;
        end
      end
      ST_ACK_HIGH: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!dq_s) begin
          state_d   = ST_BIT_LOW;
          bit_idx_d = 6'd0;
        end else begin
          state_d = ST_ACK_HIGH;
        end
      end
      ST_BIT_LOW: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (dq_s) begin
          state_d = ST_BIT_HIGH;
        end else begin
          state_d = ST_BIT_LOW;
        end
      end
      ST_BIT_HIGH: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!dq_s) begin
          shift_d = {shift_q[38:0], (us_inc_s > THRESH_US)};
          if (bit_idx_q == 6'd39) begin
            state_d = ST_CHECK;
          end else begin
            bit_idx_d = bit_idx_q + 6'd1;
            state_d   = ST_BIT_LOW;
          end
        end else begin
          state_d = ST_BIT_HIGH;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (checksum_ok(shift_q)) begin
          hum_d  = shift_q[39:24];
          temp_d = shift_q[23:8];
          dv_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      seen_high_d = 1'b0;
    end else begin
      seen_high_d = seen_high_d;
    end
  end

  // Prescaler and phase counter restart on every state change and rest in IDLE.
  always_comb begin
    presc_d  = presc_q;
    us_cnt_d = us_cnt_q;
    if (state_change_s || (state_q == ST_IDLE)) begin
      presc_d  = '0;
      us_cnt_d = 16'd0;
    end else if (tick_s) begin
      presc_d  = '0;
      us_cnt_d = us_inc_s;
    end else begin
      presc_d  = presc_q + {{(PW-1){1'b0}}, 1'b1};
      us_cnt_d = us_cnt_q;
    end
  end

  // State, counters and registered outputs; reset releases the bus at once.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      us_cnt_q    <= 16'd0;
      bit_idx_q   <= 6'd0;
      shift_q     <= 40'd0;
      seen_high_q <= 1'b0;
      hum_q       <= 16'd0;
      temp_q      <= 16'd0;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      us_cnt_q    <= us_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      seen_high_q <= seen_high_d;
      hum_q       <= hum_d;
      temp_q      <= temp_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      dq_oe_q     <= (state_d == ST_START_LOW);
    end
  end

  assign dq_oe       = dq_oe_q;
  assign humidity    = hum_q;
  assign temperature = temp_q;
  assign data_valid  = dv_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Scoreboard bench for dht11_reader with a timing-scaled DHT11 sensor model.
module tb_dht11_reader;

  localparam int CPU      = 2;
  localparam int START_US = 100;
  localparam int THRESH   = 50;
  localparam int TMO      = 200;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic        sensor_low = 1'b0;
  logic        dq_in;
  logic        dq_oe;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        data_valid;
  logic        busy;
  logic        err;

  // Open-drain bus: low if host or sensor pulls, otherwise pulled up.
  assign dq_in = ~(dq_oe | sensor_low);

  dht11_reader #(
    .CYCLES_PER_US(CPU),
    .START_LOW_US (START_US),
    .BIT_THRESH_US(THRESH),
    .TIMEOUT_US   (TMO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample_en  (sample_en),
    .dq_in      (dq_in),
    .dq_oe      (dq_oe),
    .humidity   (humidity),
    .temperature(temperature),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        dv;
    logic        err;
    logic [15:0] hum;
    logic [15:0] temp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   w_arr[40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic dv, input logic e, input logic [15:0] h, input logic [15:0] t);
    exp_t r;
    r.dv = dv; r.err = e; r.hum = h; r.temp = t;
    return r;
  endfunction

  // Monitor: start-pulse width and end-of-transaction scoreboard compare.
  int   oe_run = 0;
  int   dv_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (dq_oe) begin
      oe_run++;
    end else if (oe_run != 0) begin
      if (!rst) check("start_low_width", 32'(oe_run), 32'(START_US * CPU));
      oe_run = 0;
    end
    if (data_valid) dv_cnt++;
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_txn", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_valid_count", 32'(dv_cnt), 32'(e.dv));
        check("err", 32'(err), 32'(e.err));
        check("humidity", 32'(humidity), 32'(e.hum));
        check("temperature", 32'(temperature), 32'(e.temp));
      end
      dv_cnt = 0;
    end
    prev_busy = busy;
  end

  task automatic wait_us(input int us);
    repeat (us * CPU) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    sample_en = 1'b1;
    @(negedge clk_in);
    sample_en = 1'b0;
  endtask

  task automatic wait_oe_fall();
    int n = 0;
    while (!dq_oe && n < 20) begin @(negedge clk_in); n++; end
    while (dq_oe && n < START_US * CPU + 100) begin @(negedge clk_in); n++; end
    check("oe_released", 32'(dq_oe), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin @(negedge clk_in); n++; end
    check("txn_done", 32'(busy), 32'd0);
    repeat (10) @(negedge clk_in);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_oe_clear", 32'(dq_oe), 32'd0);
    check("rst_busy_clear", 32'(busy), 32'd0);
    check("rst_hum_clear", 32'(humidity), 32'd0);
    repeat (2) @(posedge clk_in);
    #2 rst = 1'b0;
  endtask

  task automatic set_frame(input logic [39:0] d);
    for (int k = 0; k < 40; k++) w_arr[k] = d[39-k] ? 70 : 27;
  endtask

  // Sensor response after host release; abort_bit >= 0 resets mid high phase.
  task automatic sensor_send(input int abort_bit);
    wait_us(20);
    sensor_low = 1'b1; wait_us(80);
    sensor_low = 1'b0; wait_us(80);
    for (int k = 0; k < 40; k++) begin
      sensor_low = 1'b1; wait_us(10);
      sensor_low = 1'b0;
      if (k == abort_bit) begin
        wait_us(w_arr[k] / 2);
        do_reset();
        return;
      end
      wait_us(w_arr[k]);
    end
    sensor_low = 1'b1; wait_us(10);
    sensor_low = 1'b0;
  endtask

  task automatic run_frame(input logic [39:0] d, input exp_t e, input int abort_bit);
    set_frame(d);
    exp_q.push_back(e);
    pulse_start();
    wait_oe_fall();
    sensor_send(abort_bit);
    wait_idle();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    check("reset_dq_oe", 32'(dq_oe), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_humidity", 32'(humidity), 32'd0);
    check("reset_temperature", 32'(temperature), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    // Nominal frame.
    run_frame(40'h37_00_19_00_50, mk(1'b1, 1'b0, 16'h3700, 16'h1900), -1);
    // Checksum fault keeps previous readings.
    run_frame(40'h37_00_19_00_51, mk(1'b0, 1'b1, 16'h3700, 16'h1900), -1);

    // No sensor: timeout 200 us after release.
    exp_q.push_back(mk(1'b0, 1'b1, 16'h3700, 16'h1900));
    pulse_start();
    wait_oe_fall();
    n = 0;
    while (!err && n < 1000) begin @(negedge clk_in); n++; end
    check("timeout_window", 32'((n >= TMO * CPU - CPU) && (n <= TMO * CPU + CPU)), 32'd1);
    wait_idle();

    // Start while busy is ignored; accepted start clears err.
    set_frame(40'h40_00_1E_00_5E);
    exp_q.push_back(mk(1'b1, 1'b0, 16'h4000, 16'h1E00));
    pulse_start();
    repeat (2) @(negedge clk_in);
    check("start_clears_err", 32'(err), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_us(START_US / 2);
    pulse_start();
    wait_oe_fall();
    sensor_send(-1);
    wait_idle();
    repeat (50) @(negedge clk_in);
    check("no_queued_start", 32'(busy), 32'd0);

    // Reset during BIT_HIGH of bit 20, then a normal frame.
    run_frame(40'h37_00_19_00_50, mk(1'b0, 1'b0, 16'h0000, 16'h0000), 20);
    run_frame(40'h37_00_19_00_50, mk(1'b1, 1'b0, 16'h3700, 16'h1900), -1);

    // Reset during START_LOW, then a normal frame.
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000));
    pulse_start();
    wait_us(20);
    do_reset();
    wait_idle();
    run_frame(40'h37_00_19_00_50, mk(1'b1, 1'b0, 16'h3700, 16'h1900), -1);

    // Threshold boundary: 49 and 50 us decode as 0, 51 us as 1.
    set_frame(40'h2D_00_1A_05_4C);
    w_arr[0] = 49;
    w_arr[1] = 50;
    w_arr[2] = 51;
    exp_q.push_back(mk(1'b1, 1'b0, 16'h2D00, 16'h1A05));
    pulse_start();
    wait_oe_fall();
    sensor_send(-1);
    wait_idle();

    repeat (20) @(negedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Consumer of the periodic `sample_en` pulse that drives temperature/humidity sampling on the miniCar.
- On each accepted `sample_en`, performs one DHT11 single-wire transaction: host start pulse, sensor acknowledge, 40 data bits.
- Checks the checksum and publishes humidity and temperature registers with a one-cycle valid strobe.
- Sits between the sampling-enable generator and the display/telemetry logic; the top level maps `dq_oe`/`dq_in` onto an open-drain IOBUF.

Parameters:
- CYCLES_PER_US, 10, clk_in cycles per microsecond (10 MHz system clock).
- START_LOW_US, 18000, host low-pulse width on the bus, in µs.
- BIT_THRESH_US, 50, data-bit high width strictly above this decodes as '1'.
- TIMEOUT_US, 200, maximum µs in any sensor-driven phase before abort.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  start request, one-cycle pulse or level.
- dq_in  input  1  raw bus level (asynchronous to clk_in).
- dq_oe  output  1  1 = pull bus low; 0 = release (pull-up holds high).
- humidity  output  16  {integer byte, decimal byte}.
- temperature  output  16  {integer byte, decimal byte}.
- data_valid  output  1  one-cycle strobe when humidity/temperature update.
- busy  output  1  high from accepted start until return to IDLE.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Interface: one clock `clk_in`; reset `rst` is asynchronous and active-high.
- Reset values: dq_oe=0, humidity=0, temperature=0, data_valid=0, busy=0, err=0, state=IDLE, all counters 0.
- Reset asserted mid-transaction releases the bus immediately (asynchronous clear of dq_oe).
- `dq_in` passes through a 2-FF synchronizer (dq_s); all edge and level decisions use dq_s. Edge detection adds 2–3 cycles of latency, which is acceptable.
- µs tick: prescaler counts 0..CYCLES_PER_US-1 and pulses `tick` on wrap. Phase counter `us_cnt` (16 bit) clears on every state change and increments on tick, saturating at 0xFFFF.
- FSM states, in order:
  - IDLE: busy=0. If sample_en=1, go to START_LOW, set busy=1, clear err. sample_en in any other state is ignored (no queuing).
  - START_LOW: dq_oe=1. When us_cnt==START_LOW_US, dq_oe=0 and go to WAIT_ACK.
  - WAIT_ACK: wait for dq_s low → ACK_LOW.
  - ACK_LOW: wait for dq_s high → ACK_HIGH.
  - ACK_HIGH: wait for dq_s low → BIT_LOW, bit_idx=0.
  - BIT_LOW: wait for dq_s high → BIT_HIGH.
  - BIT_HIGH: wait for dq_s low. Shift bit (us_cnt>BIT_THRESH_US) into a 40-bit shift register, MSB first. If bit_idx==39 go to CHECK, else bit_idx+1 and go to BIT_LOW.
  - CHECK: one cycle. sum = (b4+b3+b2+b1) mod 256, where b4 = data[39:32] … b1 = data[15:8], compared with b0 = data[7:0].
    - Match: humidity=data[39:24], temperature=data[23:8], data_valid=1 for this cycle, go to IDLE.
    - Mismatch: err=1, outputs unchanged, go to IDLE.
- Timeout: in WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW and BIT_HIGH, us_cnt reaching TIMEOUT_US sets err=1, drops dq_oe if asserted, and returns to IDLE. No data_valid in this case.
- The last bit's falling edge is the sensor's end-of-frame low (50 µs). The FSM does not wait for the bus to return high; the next transaction's START_LOW is a separate 18 ms host pulse.
- Latency: data_valid occurs 1 cycle after the synchronized falling edge that ends bit 39.
- dq_oe is asserted only in START_LOW. The block never drives the bus high.
- Outputs hold their values between transactions and across errors.

Test Plan:
- Nominal frame: sensor model answers with bytes 0x37,0x00,0x19,0x00,0x50 (bits 0 = 27 µs high, 1 = 70 µs high). Required: dq_oe low exactly 180000 cycles; then humidity=0x3700, temperature=0x1900, one-cycle data_valid, err=0, busy falls.
- Checksum fault: same frame with last byte 0x51. Required: err=1, no data_valid, humidity/temperature keep previous values.
- No sensor: bus stays high after release. Required: err=1 at 200 µs (±1 tick) after dq_oe falls, busy=0.
- Start while busy: second sample_en pulse 5 ms into START_LOW. Required: ignored; one transaction, single data_valid. The next sample_en after IDLE starts a new transaction and clears err.
- Reset mid-operation: assert rst during BIT_HIGH of bit 20, and separately during START_LOW. Required: dq_oe=0 in the same cycle, all outputs return to reset values, and the next sample_en completes a frame normally.
- Threshold boundary: bit high widths of 49, 50 and 51 µs. Required: decode as 0, 0, 1 respectively.
